// File: rtl/phone_cmd_decoder.sv
// phone_cmd_decoder: parses framed command packets from the Bluetooth UART
// receiver (SYNC, CMD, LEN, payload, CHK) and updates the rider settings.
// Rejected packets (oversize LEN, bad checksum, inter-byte timeout) are
// counted in a saturating error counter.
module phone_cmd_decoder #(
  parameter int MAX_LEN        = 4,
  parameter int TIMEOUT_CYCLES = 5000000,
  parameter int HR_MIN         = 60,
  parameter int HR_MAX         = 220,
  parameter int HR_DEFAULT     = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       received,
  input  logic [7:0] rx_byte,
  output logic [7:0] heart_cap,
  output logic [2:0] assist_level,
  output logic [1:0] light_override,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic [7:0] err_count
);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int IDX_W = $clog2(MAX_LEN + 1);
  localparam int TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [7:0]      HR_MIN_B  = 8'(HR_MIN);
  localparam logic [7:0]      HR_MAX_B  = 8'(HR_MAX);
  localparam logic [7:0]      HR_DEF_B  = 8'(HR_DEFAULT);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_CMD = 3'd1,
    GET_LEN = 3'd2,
    GET_PAY = 3'd3,
    GET_CHK = 3'd4
  } state_t;

  // Clamp a requested heart-rate cap into the accepted band.
  function automatic logic [7:0] clamp_hr(input logic [7:0] v);
    logic [7:0] r;
    if (v < HR_MIN_B) begin
      r = HR_MIN_B;
    end else if (v > HR_MAX_B) begin
      r = HR_MAX_B;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Saturate a requested assist level to the 0..7 range.
  function automatic logic [2:0] clamp_assist(input logic [7:0] v);
    logic [2:0] r;
    if (v > 8'd7) begin
      r = 3'd7;
    end else begin
      r = v[2:0];
    end
    return r;
  endfunction

  state_t           state_r, state_s;
  logic [7:0]       xor_r, xor_s;
  logic [7:0]       cmd_r, cmd_s;
  logic [IDX_W-1:0] len_r, len_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  // Only payload[0] drives any command; later bytes are checksummed only.
  logic [7:0]       pay0_r, pay0_s;
  logic [TO_W-1:0]  to_cnt_r, to_cnt_s;
  logic             err_inc_s;
  logic             accept_s;

  // Parser next-state, checksum accumulation and inter-byte timeout.
  always_comb begin
    state_s   = state_r;
    xor_s     = xor_r;
    cmd_s     = cmd_r;
    len_s     = len_r;
    idx_s     = idx_r;
    pay0_s    = pay0_r;
    to_cnt_s  = to_cnt_r;
    err_inc_s = 1'b0;
    accept_s  = 1'b0;
    if (received) begin
      // A byte always restarts the inter-byte timer, even on the last tick.
      to_cnt_s = {TO_W{1'b0}};
      case (state_r)
        IDLE: begin
          if (rx_byte == SYNC_BYTE) begin
            state_s = GET_CMD;
          end else begin
            state_s = IDLE;
          end
        end
        GET_CMD: begin
          cmd_s   = rx_byte;
          xor_s   = rx_byte;
          state_s = GET_LEN;
        end
        GET_LEN: begin
          xor_s = xor_r ^ rx_byte;
          idx_s = IDX_ZERO;
          if (rx_byte > MAX_LEN_B) begin
            err_inc_s = 1'b1;
            state_s   = IDLE;
          end else if (rx_byte == 8'h00) begin
            len_s   = IDX_ZERO;
            state_s = GET_CHK;
          end else begin
            len_s   = rx_byte[IDX_W-1:0];
            state_s = GET_PAY;
          end
        end
        GET_PAY: begin
          // 0xA5 is plain data here; framing is by length only.
          xor_s = xor_r ^ rx_byte;
          if (idx_r == IDX_ZERO) begin
            pay0_s = rx_byte;
          end else begin
            pay0_s = pay0_r;
          end
          idx_s = idx_r + IDX_ONE;
          if (idx_s == len_r) begin
            state_s = GET_CHK;
          end else begin
            state_s = GET_PAY;
          end
        end
        GET_CHK: begin
          if (rx_byte == xor_r) begin
            accept_s = 1'b1;
          end else begin
            err_inc_s = 1'b1;
          end
          state_s = IDLE;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end else if (state_r == IDLE) begin
      to_cnt_s = {TO_W{1'b0}};
    end else if (to_cnt_r == TO_LAST) begin
      state_s   = IDLE;
      err_inc_s = 1'b1;
      to_cnt_s  = {TO_W{1'b0}};
    end else begin
      to_cnt_s = to_cnt_r + TO_W'(1);
    end
  end

  // Parser state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      xor_r    <= 8'h00;
      cmd_r    <= 8'h00;
      len_r    <= IDX_ZERO;
      idx_r    <= IDX_ZERO;
      pay0_r   <= 8'h00;
      to_cnt_r <= {TO_W{1'b0}};
    end else begin
      state_r  <= state_s;
      xor_r    <= xor_s;
      cmd_r    <= cmd_s;
      len_r    <= len_s;
      idx_r    <= idx_s;
      pay0_r   <= pay0_s;
      to_cnt_r <= to_cnt_s;
    end
  end

  // Rider-setting registers, accept pulse and saturating error count.
  always_ff @(posedge clk) begin
    if (reset) begin
      heart_cap      <= HR_DEF_B;
      assist_level   <= 3'd0;
      light_override <= 2'd0;
      cmd_valid      <= 1'b0;
      cmd_code       <= 8'h00;
      err_count      <= 8'h00;
    end else begin
      cmd_valid <= accept_s;
      if (accept_s) begin
        cmd_code <= cmd_r;
        // Commands that need a payload byte do nothing when LEN is 0.
        if (len_r != IDX_ZERO) begin
          case (cmd_r)
            8'h01:   heart_cap      <= clamp_hr(pay0_r);
            8'h02:   assist_level   <= clamp_assist(pay0_r);
            8'h03:   light_override <= pay0_r[1:0];
            default: heart_cap      <= heart_cap;
          endcase
        end
      end
      // Error sources are mutually exclusive per cycle, so +1 covers them all.
      if (err_inc_s && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_phone_cmd_decoder.sv
// Self-checking bench for phone_cmd_decoder with a packet-level reference
// model; runs with a short timeout so the timeout path is reachable.
module tb_phone_cmd_decoder;

  localparam int MAX_LEN = 4;
  localparam int TO_CYC  = 100;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       received = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] heart_cap;
  logic [2:0] assist_level;
  logic [1:0] light_override;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic [7:0] err_count;

  int n_pass = 0;
  int n_total = 0;
  int pulse_cnt = 0;

  logic [7:0] exp_hr, exp_code, exp_err;
  logic [2:0] exp_as;
  logic [1:0] exp_lt;
  int         exp_pulses = 0;

  phone_cmd_decoder #(
    .MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TO_CYC),
    .HR_MIN(60), .HR_MAX(220), .HR_DEFAULT(200)
  ) dut (
    .clk(clk), .reset(reset), .received(received), .rx_byte(rx_byte),
    .heart_cap(heart_cap), .assist_level(assist_level),
    .light_override(light_override), .cmd_valid(cmd_valid),
    .cmd_code(cmd_code), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Count every cycle cmd_valid is high, sampled mid-cycle.
  always @(negedge clk) begin
    if (cmd_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic send_byte(input logic [7:0] b);
    received = 1'b1;
    rx_byte  = b;
    @(posedge clk);
    #1;
    received = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_q(input bq_t q);
    foreach (q[i]) send_byte(q[i]);
  endtask

  function automatic bq_t make_pkt(input logic [7:0] cmd, input int len,
                                   input logic [7:0] p0, input bit good);
    bq_t q;
    logic [7:0] x;
    logic [7:0] b;
    q.push_back(8'hA5);
    q.push_back(cmd);
    q.push_back(8'(len));
    x = cmd ^ 8'(len);
    if (len <= MAX_LEN) begin
      for (int i = 0; i < len; i++) begin
        b = (i == 0) ? p0 : 8'($urandom);
        q.push_back(b);
        x = x ^ b;
      end
      q.push_back(good ? x : ~x);
    end
    return q;
  endfunction

  task automatic model_reset();
    exp_hr   = 8'd200;
    exp_as   = 3'd0;
    exp_lt   = 2'd0;
    exp_code = 8'h00;
    exp_err  = 8'h00;
  endtask

  task automatic err_bump();
    if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
  endtask

  // Packet-level rule: oversize LEN or wrong XOR rejects, else apply command.
  task automatic model_packet(input bq_t q, output bit acc);
    int len;
    logic [7:0] x;
    logic [7:0] p0;
    acc = 1'b0;
    len = int'(q[2]);
    if (len > MAX_LEN) begin
      err_bump();
    end else begin
      x = q[1] ^ q[2];
      for (int i = 0; i < len; i++) x = x ^ q[3 + i];
      if (q[3 + len] !== x) begin
        err_bump();
      end else begin
        acc = 1'b1;
        exp_pulses = exp_pulses + 1;
        exp_code = q[1];
        p0 = q[3];
        if (len >= 1) begin
          case (q[1])
            8'h01: exp_hr = (p0 < 8'd60) ? 8'd60 : ((p0 > 8'd220) ? 8'd220 : p0);
            8'h02: exp_as = (p0 > 8'd7) ? 3'd7 : p0[2:0];
            8'h03: exp_lt = p0[1:0];
            default: exp_lt = exp_lt;
          endcase
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    model_reset();
    n_total++;
    if ({heart_cap, assist_level, light_override, cmd_code, err_count} !==
        {exp_hr, exp_as, exp_lt, exp_code, exp_err})
      $display("FAIL reset_regs: got %h expected %h",
               {heart_cap, assist_level, light_override, cmd_code, err_count},
               {exp_hr, exp_as, exp_lt, exp_code, exp_err});
    else n_pass++;
    n_total++;
    if (cmd_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", cmd_valid);
    else n_pass++;
  endtask

  task automatic test_heart_cap();
    bq_t q;
    bit acc;
    int base;
    logic [7:0] vals[3];
    logic [7:0] want[3];
    vals = '{8'd150, 8'd250, 8'd30};
    want = '{8'd150, 8'd220, 8'd60};
    for (int k = 0; k < 3; k++) begin
      base = pulse_cnt;
      q = make_pkt(8'h01, 1, vals[k], 1'b1);
      send_q(q);
      model_packet(q, acc);
      n_total++;
      if (cmd_valid !== 1'b1) $display("FAIL hr_valid_hi[%0d]: got %b expected 1", k, cmd_valid);
      else n_pass++;
      n_total++;
      if (heart_cap !== want[k]) $display("FAIL hr_value[%0d]: got %0d expected %0d", k, heart_cap, want[k]);
      else n_pass++;
      n_total++;
      if ({heart_cap, assist_level, light_override, cmd_code, err_count} !==
          {exp_hr, exp_as, exp_lt, exp_code, exp_err})
        $display("FAIL hr_regs[%0d]: got %h expected %h", k,
                 {heart_cap, assist_level, light_override, cmd_code, err_count},
                 {exp_hr, exp_as, exp_lt, exp_code, exp_err});
      else n_pass++;
      idle(1);
      n_total++;
      if (cmd_valid !== 1'b0) $display("FAIL hr_valid_lo[%0d]: got %b expected 0", k, cmd_valid);
      else n_pass++;
      n_total++;
      if (pulse_cnt - base !== 1) $display("FAIL hr_pulses[%0d]: got %0d expected 1", k, pulse_cnt - base);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    bq_t p1, p2;
    bit acc;
    int base;
    base = pulse_cnt;
    p1 = '{8'hA5, 8'h02, 8'h01, 8'h05, 8'h06};
    p2 = '{8'hA5, 8'h03, 8'h01, 8'h03, 8'h01};
    send_q(p1);
    model_packet(p1, acc);
    n_total++;
    if (assist_level !== 3'd5 || cmd_valid !== 1'b1)
      $display("FAIL b2b_first: got assist=%0d valid=%b expected assist=5 valid=1", assist_level, cmd_valid);
    else n_pass++;
    send_q(p2);
    model_packet(p2, acc);
    n_total++;
    if ({heart_cap, assist_level, light_override, cmd_code, err_count} !==
        {exp_hr, exp_as, exp_lt, exp_code, exp_err})
      $display("FAIL b2b_regs: got %h expected %h",
               {heart_cap, assist_level, light_override, cmd_code, err_count},
               {exp_hr, exp_as, exp_lt, exp_code, exp_err});
    else n_pass++;
    idle(1);
    n_total++;
    if (pulse_cnt - base !== 2) $display("FAIL b2b_pulses: got %0d expected 2", pulse_cnt - base);
    else n_pass++;
  endtask

  task automatic test_errors();
    bq_t q;
    bit acc;
    int base;
    bq_t pkts[3];
    pkts[0] = '{8'hA5, 8'h01, 8'h01, 8'h96, 8'h00};
    pkts[1] = '{8'hA5, 8'h07, 8'h05};
    pkts[2] = '{8'hA5, 8'h04, 8'h00, 8'h04};
    for (int k = 0; k < 3; k++) begin
      base = pulse_cnt;
      q = pkts[k];
      send_q(q);
      model_packet(q, acc);
      n_total++;
      if (cmd_valid !== acc) $display("FAIL err_valid[%0d]: got %b expected %b", k, cmd_valid, acc);
      else n_pass++;
      n_total++;
      if ({heart_cap, assist_level, light_override, cmd_code, err_count} !==
          {exp_hr, exp_as, exp_lt, exp_code, exp_err})
        $display("FAIL err_regs[%0d]: got %h expected %h", k,
                 {heart_cap, assist_level, light_override, cmd_code, err_count},
                 {exp_hr, exp_as, exp_lt, exp_code, exp_err});
      else n_pass++;
      idle(1);
      n_total++;
      if (pulse_cnt - base !== int'(acc)) $display("FAIL err_pulses[%0d]: got %0d expected %0d", k, pulse_cnt - base, acc);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    bq_t q;
    bit acc;
    int base;
    // Abandon a packet after CMD; the 100th idle cycle times it out.
    send_byte(8'hA5);
    send_byte(8'h01);
    idle(TO_CYC - 1);
    n_total++;
    if (err_count !== exp_err) $display("FAIL to_early: got %0d expected %0d", err_count, exp_err);
    else n_pass++;
    idle(1);
    err_bump();
    n_total++;
    if (err_count !== exp_err) $display("FAIL to_fire: got %0d expected %0d", err_count, exp_err);
    else n_pass++;
    idle(TO_CYC + 5);
    n_total++;
    if (err_count !== exp_err) $display("FAIL to_once: got %0d expected %0d", err_count, exp_err);
    else n_pass++;
    // Back in IDLE: a stray byte is ignored and a valid packet is accepted.
    base = pulse_cnt;
    send_byte(8'h01);
    q = make_pkt(8'h02, 1, 8'd3, 1'b1);
    send_q(q);
    model_packet(q, acc);
    idle(1);
    n_total++;
    if ({assist_level, err_count} !== {exp_as, exp_err} || pulse_cnt - base !== 1)
      $display("FAIL to_recover: got %h/%0d expected %h/1", {assist_level, err_count}, pulse_cnt - base, {exp_as, exp_err});
    else n_pass++;
    // A byte on the last idle tick wins over the timeout.
    base = pulse_cnt;
    q = make_pkt(8'h01, 1, 8'd99, 1'b1);
    send_byte(q[0]);
    send_byte(q[1]);
    idle(TO_CYC - 1);
    send_byte(q[2]);
    send_byte(q[3]);
    send_byte(q[4]);
    model_packet(q, acc);
    idle(1);
    n_total++;
    if ({heart_cap, err_count} !== {exp_hr, exp_err} || pulse_cnt - base !== 1)
      $display("FAIL to_cancel: got %h/%0d expected %h/1", {heart_cap, err_count}, pulse_cnt - base, {exp_hr, exp_err});
    else n_pass++;
  endtask

  task automatic test_random();
    bq_t q;
    bit acc;
    logic [7:0] junk;
    logic [7:0] p0;
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        junk = 8'($urandom);
        if (junk == 8'hA5) junk = 8'h00;
        send_byte(junk);
      end
      idle($urandom_range(0, 3));
      p0 = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
      q = make_pkt(8'($urandom_range(1, 6)), $urandom_range(0, 6), p0, $urandom_range(0, 4) != 0);
      send_q(q);
      model_packet(q, acc);
      n_total++;
      if (cmd_valid !== acc) $display("FAIL rnd_valid[%0d]: got %b expected %b", k, cmd_valid, acc);
      else n_pass++;
      n_total++;
      if ({heart_cap, assist_level, light_override, cmd_code, err_count} !==
          {exp_hr, exp_as, exp_lt, exp_code, exp_err})
        $display("FAIL rnd_regs[%0d]: got %h expected %h", k,
                 {heart_cap, assist_level, light_override, cmd_code, err_count},
                 {exp_hr, exp_as, exp_lt, exp_code, exp_err});
      else n_pass++;
    end
    idle(1);
    n_total++;
    if (pulse_cnt !== exp_pulses) $display("FAIL rnd_pulses: got %0d expected %0d", pulse_cnt, exp_pulses);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int base;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h01);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    model_reset();
    n_total++;
    if ({heart_cap, assist_level, light_override, cmd_code, err_count, cmd_valid} !==
        {exp_hr, exp_as, exp_lt, exp_code, exp_err, 1'b0})
      $display("FAIL mid_reset_regs: got %h expected %h",
               {heart_cap, assist_level, light_override, cmd_code, err_count},
               {exp_hr, exp_as, exp_lt, exp_code, exp_err});
    else n_pass++;
    base = pulse_cnt;
    send_byte(8'h96);
    send_byte(8'h97);
    idle(2);
    n_total++;
    if ({heart_cap, err_count} !== {exp_hr, exp_err} || pulse_cnt !== base)
      $display("FAIL mid_reset_tail: got %h/%0d expected %h/%0d", {heart_cap, err_count}, pulse_cnt, {exp_hr, exp_err}, base);
    else n_pass++;
  endtask

  task automatic test_saturation();
    bq_t q;
    bit acc;
    int base;
    base = pulse_cnt;
    for (int k = 0; k < 300; k++) begin
      q = make_pkt(8'h01, 1, 8'h96, 1'b0);
      send_q(q);
      model_packet(q, acc);
    end
    idle(1);
    n_total++;
    if (err_count !== 8'd255 || err_count !== exp_err)
      $display("FAIL sat_err: got %0d expected %0d", err_count, exp_err);
    else n_pass++;
    n_total++;
    if (heart_cap !== exp_hr || pulse_cnt !== base)
      $display("FAIL sat_nochange: got hr=%0d pulses=%0d expected hr=%0d pulses=%0d", heart_cap, pulse_cnt - base, exp_hr, 0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_heart_cap();
    test_back_to_back();
    test_errors();
    test_timeout();
    test_random();
    test_reset_mid();
    exp_pulses = pulse_cnt;
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
